// File: rtl/prio_pkg.sv
// Shared types and helpers for the priority/round-robin grant arbiter.
package prio_pkg;

  typedef enum logic [0:0] {
    IDLE,
    HOLD
  } state_e;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Index width that stays at least one bit wide for tiny N.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = $clog2(n);
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational winner select: MSB-first fixed priority, or a descending cyclic search from base.
module prio_pick
  import prio_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] base_i,
  input  logic             rr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [N-1:0]     onehot_o,
  output logic             any_o
);

  logic [N-1:0] low_mask;
  logic [N-1:0] low_req;

  function automatic logic [IDX_W-1:0] msb_idx(input logic [N-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // Searching base, base-1, ..., 0 then wrapping to N-1 is the same as taking the highest
  // request at or below base, falling back to the highest request overall.
  always_comb begin
    low_mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      low_mask[i] = (i <= 32'(base_i));
    end
    low_req = req_i & low_mask;
    any_o   = |req_i;
    if (rr_i == MODE_RR && |low_req) begin
      idx_o = msb_idx(low_req);
    end else begin
      idx_o = msb_idx(req_i);
    end
    onehot_o = any_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/prio_grant_arb.sv
// N-way arbiter presenting a registered winner (index + one-hot) on a valid/ready handshake.
module prio_grant_arb
  import prio_pkg::*;
#(
  parameter  int unsigned N     = 8,
  localparam int unsigned IDX_W = clog2_min1(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_i,
  input  logic             rr_mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [IDX_W-1:0] out_idx_o,
  output logic [N-1:0]     out_onehot_o
);

  localparam logic [IDX_W-1:0] PtrMax = IDX_W'(N - 1);

  state_e           state_q;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             valid_q;
  logic [IDX_W-1:0] idx_q;
  logic [N-1:0]     onehot_q;

  logic [IDX_W-1:0] pick_idx;
  logic [N-1:0]     pick_onehot;
  logic             pick_any;

  // On a transfer the pointer moves past the granted index so the pick made at the
  // same edge already sees the advanced pointer. Wrap is modulo N.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == HOLD && out_ready_i && rr_mode_i == MODE_RR) begin
      ptr_d = (idx_q == '0) ? PtrMax : idx_q - IDX_W'(1);
    end
  end

  prio_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i    (req_i),
    .base_i   (ptr_d),
    .rr_i     (rr_mode_i),
    .idx_o    (pick_idx),
    .onehot_o (pick_onehot),
    .any_o    (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= PtrMax;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_any) begin
            idx_q    <= pick_idx;
            onehot_q <= pick_onehot;
            valid_q  <= 1'b1;
            state_q  <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready_i) begin
            ptr_q <= ptr_d;
            if (pick_any) begin
              idx_q    <= pick_idx;
              onehot_q <= pick_onehot;
            end else begin
              // idx_q deliberately keeps its last value while idle.
              valid_q  <= 1'b0;
              onehot_q <= '0;
              state_q  <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid_o  = valid_q;
  assign out_idx_o    = idx_q;
  assign out_onehot_o = onehot_q;

endmodule

// File: tb/tb_prio_grant_arb.sv
// Directed and random checks of prio_grant_arb (N=8 and N=5) against a behavioural model.
module tb_prio_grant_arb;
  import prio_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req8;
  logic       rr8, rdy8;
  logic       val8;
  logic [2:0] idx8;
  logic [7:0] oh8;
  logic [4:0] req5;
  logic       rr5, rdy5;
  logic       val5;
  logic [2:0] idx5;
  logic [4:0] oh5;

  int checks = 0;
  int errors = 0;

  // Model state per instance: [0] is N=8, [1] is N=5.
  bit m_val[2];
  int m_idx[2];
  int m_ptr[2];

  always #5 clk = ~clk;

  prio_grant_arb #(.N(8)) dut8 (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req8),
    .rr_mode_i    (rr8),
    .out_valid_o  (val8),
    .out_ready_i  (rdy8),
    .out_idx_o    (idx8),
    .out_onehot_o (oh8)
  );

  prio_grant_arb #(.N(5)) dut5 (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req5),
    .rr_mode_i    (rr5),
    .out_valid_o  (val5),
    .out_ready_i  (rdy5),
    .out_idx_o    (idx5),
    .out_onehot_o (oh5)
  );

  // Winner per the priority rules: fixed = highest set bit; rr = first set bit scanning
  // p, p-1, ... modulo n.
  function automatic int pick_ref(input logic [63:0] r, input int p, input bit rr, input int n);
    int  w;
    bit  found;
    int  pos;
    w = 0;
    found = 1'b0;
    for (int k = 0; k < n; k++) begin
      pos = rr ? (p - k + n) % n : n - 1 - k;
      if (!found && r[pos]) begin
        w = pos;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  task automatic model_reset();
    m_val[0] = 0; m_idx[0] = 0; m_ptr[0] = 7;
    m_val[1] = 0; m_idx[1] = 0; m_ptr[1] = 4;
  endtask

  task automatic model_step(input int j, input logic [63:0] r, input bit rr, input bit rdy,
                            input int n);
    if (!m_val[j]) begin
      if (r != 0) begin
        m_idx[j] = pick_ref(r, m_ptr[j], rr, n);
        m_val[j] = 1;
      end
    end else if (rdy) begin
      if (rr) m_ptr[j] = (m_idx[j] + n - 1) % n;
      if (r != 0) m_idx[j] = pick_ref(r, m_ptr[j], rr, n);
      else m_val[j] = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("valid8", 64'(val8), 64'(m_val[0]));
    chk("onehot8", 64'(oh8), m_val[0] ? (64'd1 << m_idx[0]) : 64'd0);
    if (m_val[0]) chk("idx8", 64'(idx8), 64'(m_idx[0]));
    chk("valid5", 64'(val5), 64'(m_val[1]));
    chk("onehot5", 64'(oh5), m_val[1] ? (64'd1 << m_idx[1]) : 64'd0);
    if (m_val[1]) chk("idx5", 64'(idx5), 64'(m_idx[1]));
  endtask

  // Advance one clock, update the model from the inputs held across the edge, then compare.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      model_step(0, 64'(req8), rr8, rdy8, 8);
      model_step(1, 64'(req5), rr5, rdy5, 5);
    end
    #1;
    check_all();
  endtask

  initial begin
    int rr_seq[9];
    int wrap_seq[4];
    rr_seq   = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    wrap_seq = '{1, 0, 1, 0};

    rst_n = 1'b0;
    req8 = '0; rr8 = MODE_FIXED; rdy8 = 1'b0;
    req5 = '0; rr5 = MODE_FIXED; rdy5 = 1'b0;
    model_reset();
    #12;
    chk("reset_valid8", 64'(val8), 64'd0);
    chk("reset_idx8", 64'(idx8), 64'd0);
    chk("reset_onehot8", 64'(oh8), 64'd0);
    chk("reset_valid5", 64'(val5), 64'd0);
    rst_n = 1'b1;

    // Async reset while holding a winner.
    req8 = 8'h10;
    tick();
    chk("hold_before_rst", 64'(val8), 64'd1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_valid", 64'(val8), 64'd0);
    chk("async_rst_onehot", 64'(oh8), 64'd0);
    #1 rst_n = 1'b1;
    req8 = '0;
    tick();
    chk("post_rst_idle", 64'(val8), 64'd0);

    // Fixed priority, repeated each cycle.
    rr8 = MODE_FIXED; req8 = 8'b0010_0110; rdy8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fixed_idx", 64'(idx8), 64'd5);
      chk("fixed_onehot", 64'(oh8), 64'h20);
    end
    req8 = '0;
    tick();

    // Round-robin over all requesters; pointer still at 7 since fixed mode left it alone.
    rr8 = MODE_RR; req8 = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("rr_seq", 64'(idx8), 64'(rr_seq[i]));
    end

    // Backpressure freezes the winner even as req changes or drops.
    req8 = 8'h10;
    tick();
    chk("bp_pick", 64'(idx8), 64'd4);
    rdy8 = 1'b0; req8 = 8'h80;
    tick();
    chk("bp_hold_a", 64'(idx8), 64'd4);
    req8 = 8'h00;
    tick();
    chk("bp_hold_b", 64'(idx8), 64'd4);
    chk("bp_hold_valid", 64'(val8), 64'd1);
    rdy8 = 1'b1;
    tick();
    chk("bp_drain", 64'(val8), 64'd0);

    // rr_mode change while holding has no effect until the next pick.
    rr8 = MODE_RR; rdy8 = 1'b0; req8 = 8'h40;
    tick();
    chk("mode_hold_rr", 64'(idx8), 64'd6);
    rr8 = MODE_FIXED;
    tick();
    chk("mode_hold_fixed", 64'(idx8), 64'd6);
    rdy8 = 1'b1; req8 = 8'hC1;
    tick();
    chk("mode_switch_pick", 64'(idx8), 64'd7);
    req8 = '0;
    tick();

    // Non-power-of-2 wrap on the N=5 instance.
    rr5 = MODE_RR; rdy5 = 1'b1; req5 = 5'b00011;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wrap_seq", 64'(idx5), 64'(wrap_seq[i]));
    end
    req5 = 5'b10001;
    tick();
    chk("wrap_to_4", 64'(idx5), 64'd4);
    req5 = '0;
    tick();

    // Random traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      req8 = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      req5 = ($urandom_range(0, 3) == 0) ? 5'h00 : 5'($urandom);
      rr8  = ($urandom_range(0, 3) != 0);
      rr5  = ($urandom_range(0, 3) != 0);
      rdy8 = ($urandom_range(0, 2) != 0);
      rdy5 = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
